// File: rtl/axis_rr_arbiter_if.sv
// Stream bundle around the 4:1 packet arbiter: N upstream AXI-Stream ports in, one downstream port out.
// slave is the arbiter's view; master is the view of the surrounding sources and sink.
interface axis_rr_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int N      = 4
);
    logic [N-1:0]        s_tvalid;
    logic [N*DATA_W-1:0] s_tdata;
    logic [N-1:0]        s_tlast;
    logic [N-1:0]        s_tready;
    logic                m_tvalid;
    logic [DATA_W-1:0]   m_tdata;
    logic                m_tlast;
    logic                m_tready;

    modport slave (
        input  s_tvalid, s_tdata, s_tlast, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tlast
    );

    modport master (
        output s_tvalid, s_tdata, s_tlast, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tlast
    );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet-locked round-robin arbiter: 4 AXI-Stream requesters into one registered output stage.
// A requester keeps the grant from its first beat through its tlast beat.
module axis_rr_arbiter #(
    parameter int DATA_W = 16,
    parameter int N      = 4
) (
    input  logic              clk,
    input  logic              rst,
    axis_rr_arbiter_if.slave  bus,
    output logic [1:0]        grant,
    output logic              busy
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t            state, state_nxt;
    logic [1:0]        grant_nxt;
    logic [1:0]        last_grant, last_grant_nxt;
    logic [1:0]        sel, idx;
    logic              sel_found;
    logic [N-1:0]      ready;
    logic              out_free, s_xfer, m_xfer;
    logic              out_valid, out_last;
    logic [DATA_W-1:0] out_data;

    // The output register may accept a beat when empty or emptying this cycle.
    assign out_free = !out_valid || bus.m_tready;
    assign s_xfer   = (state == LOCK) && bus.s_tvalid[grant] && out_free;
    assign m_xfer   = out_valid && bus.m_tready;

    // Search starts one past the previous owner, so idle requesters are skipped for free.
    always_comb begin : rr_pick
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        sel       = '0;
        idx       = '0;
        sel_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = last_grant + 2'(k);
            if (!sel_found && bus.s_tvalid[idx]) begin
                sel       = idx;
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin : fsm_next
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        ready          = '0;
        busy           = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nxt = LOCK;
                    grant_nxt = sel;
                end
            end
            LOCK: begin
                busy         = 1'b1;
                ready[grant] = out_free;
                if (s_xfer && bus.s_tlast[grant]) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = grant;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin : fsm_reg
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= 2'd3;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Output stage reloads on the same edge it drains, giving one beat per cycle.
    always_ff @(posedge clk or posedge rst) begin : out_reg
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (s_xfer) begin
            out_valid <= 1'b1;
            out_data  <= bus.s_tdata[grant*DATA_W +: DATA_W];
            out_last  <= bus.s_tlast[grant];
        end else if (m_xfer) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.s_tready = ready;
    assign bus.m_tvalid = out_valid;
    assign bus.m_tdata  = out_data;
    assign bus.m_tlast  = out_last;

endmodule
